// File: rtl/router_output_arbiter.sv
// router_output_arbiter: round-robin arbiter feeding a polarity-selected even/odd buffer pair drained over so/ro.
module router_output_arbiter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              req0,
  input  logic [DATA_W-1:0] din0,
  input  logic              req1,
  input  logic [DATA_W-1:0] din1,
  output logic              ack0,
  output logic              ack1,
  input  logic              ro,
  output logic              so,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] even_buf_q, even_buf_d, odd_buf_q, odd_buf_d, wdata;
  logic even_full_q, even_full_d, odd_full_q, odd_full_d, rr_ptr_q, rr_ptr_d;
  logic tgt_full, snd_full, gnt0, gnt1;
  // polarity=1 writes odd and sends even; polarity=0 the reverse
  always_comb begin
    tgt_full = polarity ? odd_full_q : even_full_q;
    snd_full = polarity ? even_full_q : odd_full_q;
    gnt0 = req0 && (!req1 || !rr_ptr_q);
    gnt1 = req1 && (!req0 || rr_ptr_q);
    ack0 = !reset && !tgt_full && gnt0;
    ack1 = !reset && !tgt_full && gnt1;
    so = !reset && snd_full && ro;
    dout = reset ? '0 : (polarity ? even_buf_q : odd_buf_q);
    wdata = ack1 ? din1 : din0;
    even_buf_d = (!polarity && (ack0 || ack1)) ? wdata : even_buf_q;
    odd_buf_d = (polarity && (ack0 || ack1)) ? wdata : odd_buf_q;
    even_full_d = (!polarity && (ack0 || ack1)) ? 1'b1 : (polarity && so) ? 1'b0 : even_full_q;
    odd_full_d = (polarity && (ack0 || ack1)) ? 1'b1 : (!polarity && so) ? 1'b0 : odd_full_q;
    rr_ptr_d = ack0 ? 1'b1 : ack1 ? 1'b0 : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      even_buf_q <= '0;
      odd_buf_q <= '0;
      even_full_q <= 1'b0;
      odd_full_q <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      even_buf_q <= even_buf_d;
      odd_buf_q <= odd_buf_d;
      even_full_q <= even_full_d;
      odd_full_q <= odd_full_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_router_output_arbiter.sv
// tb_router_output_arbiter: directed and random stimulus against a phase-indexed buffer model.
module tb_router_output_arbiter;
  localparam int W = 64;
  logic clk = 1'b0;
  logic reset, polarity, req0, req1, ro, ack0, ack1, so;
  logic [W-1:0] din0, din1, dout;
  router_output_arbiter #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .req0(req0), .din0(din0), .req1(req1), .din1(din1),
    .ack0(ack0), .ack1(ack1), .ro(ro), .so(so), .dout(dout)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [W-1:0] mbuf [2];
  bit mfull [2];
  bit mrr, pol;
  logic o_ack0, o_ack1, o_so;
  logic [W-1:0] o_dout;
  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  // index 0 = even buffer, 1 = odd; the write side is the polarity, the send side its complement
  task automatic step(bit r, bit q0, logic [W-1:0] d0, bit q1, logic [W-1:0] d1, bit rv);
    int w, s, win;
    bit ea0, ea1, eso;
    @(negedge clk);
    reset = r; polarity = pol; req0 = q0; din0 = d0; req1 = q1; din1 = d1; ro = rv;
    #1;
    w = int'(pol);
    s = 1 - w;
    win = (q0 && q1) ? int'(mrr) : q0 ? 0 : q1 ? 1 : -1;
    ea0 = !r && !mfull[w] && win == 0;
    ea1 = !r && !mfull[w] && win == 1;
    eso = !r && mfull[s] && rv;
    chk("ack0", W'(ack0), W'(ea0));
    chk("ack1", W'(ack1), W'(ea1));
    chk("so", W'(so), W'(eso));
    chk("dout", dout, r ? '0 : mbuf[s]);
    chk("ack_onehot", W'(ack0 & ack1), '0);
    o_ack0 = ack0; o_ack1 = ack1; o_so = so; o_dout = dout;
    @(posedge clk);
    if (r) begin
      mbuf = '{default: '0};
      mfull = '{default: 1'b0};
      mrr = 1'b0;
    end else begin
      if (ea0 || ea1) begin
        mbuf[w] = ea0 ? d0 : d1;
        mfull[w] = 1'b1;
        mrr = ea0;
      end
      if (eso) mfull[s] = 1'b0;
    end
    pol = !pol;
  endtask
  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    if (pol) step(1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    mbuf = '{default: '0};
    mfull = '{default: 1'b0};
    mrr = 1'b0;
    pol = 1'b0;
    do_reset();
    chk("rst_so", W'(o_so), '0);
    chk("rst_dout", o_dout, '0);
    step(0, 1, 'hA5A5, 0, 0, 1);
    chk("t1_ack0", W'(o_ack0), W'(1));
    step(0, 0, 0, 0, 0, 1);
    chk("t1_so", W'(o_so), W'(1));
    chk("t1_dout", o_dout, 'hA5A5);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 'h1, 1, 'h2, 1);
      chk("t2_ack0", W'(o_ack0), W'(i % 2 == 0));
      chk("t2_ack1", W'(o_ack1), W'(i % 2 == 1));
      if (i > 0) chk("t2_dout", o_dout, (i % 2 == 1) ? 'h1 : 'h2);
    end
    do_reset();
    step(0, 1, 'h33, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_hold_so", W'(o_so), '0);
    step(0, 1, 'h44, 1, 'h55, 0);
    chk("t3_stall", W'(o_ack0 | o_ack1), '0);
    step(0, 0, 0, 0, 0, 1);
    chk("t3_so", W'(o_so), W'(1));
    chk("t3_dout", o_dout, 'h33);
    step(0, 1, 'h44, 0, 0, 1);
    chk("t3_resume", W'(o_ack0), W'(1));
    step(0, 0, 0, 1, 'h66, 1);
    chk("t4_ack1", W'(o_ack1), W'(1));
    chk("t4_so", W'(o_so), W'(1));
    chk("t4_dout", o_dout, 'h44);
    step(0, 1, 'h88, 0, 0, 1);
    chk("t4_dout2", o_dout, 'h66);
    step(0, 1, 'h77, 1, 'h99, 0);
    step(1, 1, 'hAA, 1, 'hBB, 1);
    chk("t5_rst_ack", W'(o_ack0 | o_ack1), '0);
    chk("t5_rst_so", W'(o_so), '0);
    step(0, 1, 'hCC, 1, 'hDD, 1);
    chk("t5_rr0", W'(o_ack0), W'(1));
    chk("t5_empty", W'(o_so), '0);
    do_reset();
    step(0, 0, 0, 1, 'h99, 1);
    chk("t6_ack1", W'(o_ack1), W'(1));
    step(0, 1, 'h10, 1, 'h20, 1);
    chk("t6_rr0", W'(o_ack0), W'(1));
    for (int i = 0; i < 3000; i++)
      step($urandom_range(63) == 0, 1'($urandom), {$urandom, $urandom},
           1'($urandom), {$urandom, $urandom}, $urandom_range(3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
